flash_spi_engine: RTL
=====================

FLASH_SPI_ENGINE -- requirements
Module: flash_spi_engine

Interface
REQ-001 Parameter PAGE_BYTES, default 256: data bytes transferred by page program and read commands.
REQ-002 Parameter RECOVER_CYC, default 2: cycles with CS high after Done_Sig before a new command is sampled; minimum 2.
REQ-003 CLK  input  1: single clock (25 MHz SPI base clock); all logic on rising edge.
REQ-004 RST  input  1: reset, synchronous, active-high.
REQ-005 cmd_type  input  4: command request; bit3=1 requests a command; bits[2:0] select the transaction type.
REQ-006 flash_cmd  input  8: opcode byte, sent verbatim as the first SPI byte.
REQ-007 flash_addr  input  24: address for sector erase, page program and read; sent MSB first.
REQ-008 Done_Sig  output  1: one-cycle pulse at transaction end.
REQ-009 mydata_o  output  8: last received SPI byte; holds its value until the next byte is received.
REQ-010 myvalid_o  output  1: one-cycle pulse when mydata_o updates.
REQ-011 flash_clk  output  1: SPI clock, mode 0, idles low.
REQ-012 flash_cs  output  1: chip select, active-low.
REQ-013 flash_datain  output  1: MOSI.
REQ-014 flash_dataout  input  1: MISO.

Function
REQ-015 Transaction table (tx bytes, rx bytes):
- 1000 read ID: opcode + 000000h, rx 2.
- 1001 write enable: opcode, rx 0.
- 1010 sector erase: opcode + flash_addr, rx 0.
- 1011 read status: opcode, rx 1.
- 1100 write disable: opcode, rx 0.
- 1101 page program: opcode + flash_addr + PAGE_BYTES data, rx 0.
- 1110 read: opcode + flash_addr, rx PAGE_BYTES.
REQ-016 FSM states: IDLE, SETUP, SHIFT, HOLD, DONE, RECOVER.
REQ-017 IDLE: when cmd_type[3]=1 at an edge (the acceptance edge), latch cmd_type, flash_cmd and flash_addr; drive flash_cs low; go to SETUP.
REQ-018 SETUP: 1 cycle with CS low and flash_clk low; MOSI presents the opcode MSB; then go to SHIFT.
REQ-019 SHIFT: each bit takes 2 cycles (flash_clk low, then high).
- MOSI changes only while flash_clk is low.
- MISO is sampled on the cycle flash_clk goes high.
- Bytes are shifted MSB first.
REQ-020 Receive phase: MOSI is held 0 while bytes are received.
REQ-021 Receive bytes: after the 8th sample of each byte, update mydata_o and pulse myvalid_o for 1 cycle.
REQ-022 Page program data: byte k (0 <= k < PAGE_BYTES) is transmitted as k[7:0].
REQ-023 HOLD: after the last bit, 1 cycle with CS low and flash_clk low; then go to DONE.
REQ-024 DONE: flash_cs high; Done_Sig high for exactly 1 cycle; go to RECOVER.
REQ-025 Latency: Done_Sig is high in cycle 16N+2 after the acceptance edge, where N = total bytes (tx + rx).
REQ-026 RECOVER: RECOVER_CYC cycles with CS high; cmd_type is ignored; then go to IDLE.
REQ-027 Re-issue: a request still asserted on IDLE entry is accepted as a new transaction, so a repeated status poll needs no idle gap.
REQ-028 Final byte visibility: mydata_o for the final received byte is valid no later than the Done_Sig cycle.
REQ-029 cmd_type 1111 (undefined): accepted; go directly to DONE with no CS or clock activity; Done_Sig pulses.
REQ-030 Input changes mid-transaction: cmd_type, flash_cmd and flash_addr changes are ignored until the next IDLE.
REQ-031 Counters: the bit counter is 3 bits; the byte counter is wide enough for 4+PAGE_BYTES bytes and does not wrap within a transaction.

Reset
REQ-032 RST=1 at any edge, including mid-transaction, forces next-cycle values:
- state IDLE;
- flash_cs=1, flash_clk=0, flash_datain=0;
- Done_Sig=0, myvalid_o=0, mydata_o=00h;
- all counters 0.
REQ-033 After RST deasserts, the first acceptance edge occurs no earlier than the next edge.

Verification
REQ-034 Write enable: cmd_type=1001, flash_cmd=06h -> MOSI bits 00000110; 8 flash_clk pulses; CS low 18 cycles; Done_Sig in cycle 18; no myvalid_o.
REQ-035 Read status: cmd_type=1011, flash_cmd=05h, MISO model returns 03h then 00h -> first transaction mydata_o=03h, myvalid_o pulses once, Done_Sig in cycle 34; re-issued poll returns 00h.
REQ-036 Read ID: cmd_type=1000, flash_cmd=90h, model returns EFh, 16h -> MOSI 90 00 00 00; two myvalid_o pulses with EFh then 16h; Done_Sig in cycle 98.
REQ-037 Page program: cmd_type=1101, flash_cmd=02h, flash_addr=00FF56h -> MOSI 02 00 FF 56 then 00..FF; 2080 flash_clk pulses; Done_Sig in cycle 4162.
REQ-038 Reset mid-read: cmd_type=1110, RST asserted at cycle 500 -> next cycle flash_cs=1, flash_clk=0, no Done_Sig; a fresh 1110 request completes normally with 256 myvalid_o pulses.
REQ-039 Held request: cmd_type held at 1001 through Done_Sig -> exactly one transaction per RECOVER window; CS high for >= RECOVER_CYC+1 cycles between transactions.

Source files
------------

// File: rtl/flash_spi_engine.sv
// SPI flash command engine: one opcode-driven transaction per request, Done_Sig 16N+2 cycles after acceptance.
// No backpressure: a new request is only sampled in IDLE, and inputs are ignored while a transaction runs.
module flash_spi_engine #(
   parameter int PAGE_BYTES  = 256,
   parameter int RECOVER_CYC = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  cmd_type,
   input  logic [7:0]  flash_cmd,
   input  logic [23:0] flash_addr,
   output logic        Done_Sig,
   output logic [7:0]  mydata_o,
   output logic        myvalid_o,
   output logic        flash_clk,
   output logic        flash_cs,
   output logic        flash_datain,
   input  logic        flash_dataout
);

   localparam int BYTE_W = $clog2(PAGE_BYTES + 5);
   localparam int REC_W  = $clog2(RECOVER_CYC + 1);
   localparam logic [BYTE_W-1:0] PP_TOTAL = BYTE_W'(PAGE_BYTES + 4);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_DONE, S_RECOVER
   } state_t;

   state_t              state_q, state_d;
   logic                cs_q, cs_d;
   logic                fclk_q, fclk_d;
   logic                mosi_q, mosi_d;
   logic                done_q, done_d;
   logic                valid_q, valid_d;
   logic [7:0]          rdata_q, rdata_d;
   logic [2:0]          bit_q, bit_d;
   logic [BYTE_W-1:0]   byte_q, byte_d;
   logic [REC_W-1:0]    rec_q, rec_d;
   logic [2:0]          type_q, type_d;
   logic [7:0]          op_q, op_d;
   logic [23:0]         addr_q, addr_d;
   logic [7:0]          tx_sr_q, tx_sr_d;
   logic [6:0]          rx_sr_q, rx_sr_d;
   logic [7:0]          next_byte;

   function automatic logic [BYTE_W-1:0] tx_total_f(input logic [2:0] ty);
      case (ty)
         3'b000, 3'b010, 3'b110: tx_total_f = BYTE_W'(4);
         3'b101:                 tx_total_f = PP_TOTAL;
         default:                tx_total_f = BYTE_W'(1);
      endcase
   endfunction

   function automatic logic [BYTE_W-1:0] all_total_f(input logic [2:0] ty);
      case (ty)
         3'b000:         all_total_f = BYTE_W'(6);
         3'b010:         all_total_f = BYTE_W'(4);
         3'b011:         all_total_f = BYTE_W'(2);
         3'b101, 3'b110: all_total_f = PP_TOTAL;
         default:        all_total_f = BYTE_W'(1);
      endcase
   endfunction

   // Byte placed on MOSI at position idx; receive positions carry zero.
   function automatic logic [7:0] tx_byte_f(input logic [2:0] ty, input logic [7:0] op,
                                            input logic [23:0] ad, input logic [BYTE_W-1:0] idx);
      logic [BYTE_W-1:0] k;
      k = idx - BYTE_W'(4);
      if (idx >= tx_total_f(ty))    tx_byte_f = 8'h00;
      else if (idx == BYTE_W'(0))   tx_byte_f = op;
      else if (idx == BYTE_W'(1))   tx_byte_f = ad[23:16];
      else if (idx == BYTE_W'(2))   tx_byte_f = ad[15:8];
      else if (idx == BYTE_W'(3))   tx_byte_f = ad[7:0];
      else                          tx_byte_f = 8'(k);
   endfunction

   always_comb begin
      state_d   = state_q;
      cs_d      = cs_q;
      fclk_d    = fclk_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      valid_d   = 1'b0;
      rdata_d   = rdata_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      rec_d     = rec_q;
      type_d    = type_q;
      op_d      = op_q;
      addr_d    = addr_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      next_byte = tx_byte_f(type_q, op_q, addr_q, byte_q + BYTE_W'(1));

      case (state_q)
         S_IDLE: begin
            if (cmd_type[3]) begin
               type_d = cmd_type[2:0];
               op_d   = flash_cmd;
               addr_d = (cmd_type[2:0] == 3'b000) ? 24'h000000 : flash_addr;
               bit_d  = 3'd0;
               byte_d = '0;
               if (cmd_type[2:0] == 3'b111) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_SETUP;
                  cs_d    = 1'b0;
                  fclk_d  = 1'b0;
                  tx_sr_d = flash_cmd;
                  mosi_d  = flash_cmd[7];
               end
            end
         end
         S_SETUP: begin
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            if (!fclk_q) begin
               fclk_d = 1'b1;
            end else begin
               // End of the high phase: sample MISO, drop the clock, advance MOSI.
               fclk_d  = 1'b0;
               rx_sr_d = {rx_sr_q[5:0], flash_dataout};
               if (bit_q == 3'd7) begin
                  bit_d = 3'd0;
                  if (byte_q >= tx_total_f(type_q)) begin
                     rdata_d = {rx_sr_q, flash_dataout};
                     valid_d = 1'b1;
                  end
                  if (byte_q == all_total_f(type_q) - BYTE_W'(1)) begin
                     state_d = S_HOLD;
                     mosi_d  = 1'b0;
                  end else begin
                     byte_d  = byte_q + BYTE_W'(1);
                     tx_sr_d = next_byte;
                     mosi_d  = next_byte[7];
                  end
               end else begin
                  bit_d   = bit_q + 3'd1;
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
                  mosi_d  = tx_sr_q[6];
               end
            end
         end
         S_HOLD: begin
            state_d = S_DONE;
            cs_d    = 1'b1;
            done_d  = 1'b1;
            byte_d  = '0;
         end
         S_DONE: begin
            state_d = S_RECOVER;
            rec_d   = '0;
         end
         S_RECOVER: begin
            if (rec_q == REC_W'(RECOVER_CYC - 1)) begin
               state_d = S_IDLE;
               rec_d   = '0;
            end else begin
               rec_d = rec_q + REC_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            fclk_d  = 1'b0;
            mosi_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         cs_q    <= 1'b1;
         fclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= 8'h00;
         bit_q   <= 3'd0;
         byte_q  <= '0;
         rec_q   <= '0;
         type_q  <= 3'd0;
         op_q    <= 8'h00;
         addr_q  <= 24'h000000;
         tx_sr_q <= 8'h00;
         rx_sr_q <= 7'h00;
      end else begin
         state_q <= state_d;
         cs_q    <= cs_d;
         fclk_q  <= fclk_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         bit_q   <= bit_d;
         byte_q  <= byte_d;
         rec_q   <= rec_d;
         type_q  <= type_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         tx_sr_q <= tx_sr_d;
         rx_sr_q <= rx_sr_d;
      end
   end

   assign Done_Sig     = done_q;
   assign mydata_o     = rdata_q;
   assign myvalid_o    = valid_q;
   assign flash_clk    = fclk_q;
   assign flash_cs     = cs_q;
   assign flash_datain = mosi_q;

endmodule
